// File: rtl/bcd_to_7seg_if.sv
// Digit-decoder bus: load enable and BCD code toward the decoder,
// registered segment drive and invalid-code flag back to the consumer.
interface bcd_to_7seg_if;
  logic       en;
  logic [3:0] BCD;
  logic [6:0] Seg;
  logic       bcd_err;

  modport master (
    output en,
    output BCD,
    input  Seg,
    input  bcd_err
  );

  modport slave (
    input  en,
    input  BCD,
    output Seg,
    output bcd_err
  );
endinterface

// File: rtl/bcd_to_7seg.sv
// Registered BCD-to-seven-segment decoder for one display digit.
// Seg[6:0] = a,b,c,d,e,f,g. One clock of latency, no combinational path
// from BCD to the outputs. Codes 10-15 raise bcd_err and either blank
// the digit or show hex glyphs A,b,C,d,E,F depending on HEX_MODE.
// ACTIVE_LOW inverts the segment bits (common-anode panels), never bcd_err.
module bcd_to_7seg #(
  parameter bit ACTIVE_LOW = 1'b0,
  parameter bit HEX_MODE   = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  bcd_to_7seg_if.slave  bus
);

  // All segments dark in the panel's own polarity.
  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'b1111111 : 7'b0000000;

  // Active-high glyph lookup (bit set = segment lit).
  function automatic logic [6:0] decode_glyph(input logic [3:0] code);
    logic [6:0] g;
    g = 7'b0000000;
    case (code)
      4'd0:  g = 7'b1111110;
      4'd1:  g = 7'b0110000;
      4'd2:  g = 7'b1101101;
      4'd3:  g = 7'b1111001;
      4'd4:  g = 7'b0110011;
      4'd5:  g = 7'b1011011;
      4'd6:  g = 7'b1011111;
      4'd7:  g = 7'b1110000;
      4'd8:  g = 7'b1111111;
      4'd9:  g = 7'b1111011;
      4'd10: g = HEX_MODE ? 7'b1110111 : 7'b0000000;
      4'd11: g = HEX_MODE ? 7'b0011111 : 7'b0000000;
      4'd12: g = HEX_MODE ? 7'b1001110 : 7'b0000000;
      4'd13: g = HEX_MODE ? 7'b0111101 : 7'b0000000;
      4'd14: g = HEX_MODE ? 7'b1001111 : 7'b0000000;
      4'd15: g = HEX_MODE ? 7'b1000111 : 7'b0000000;
      default: g = 7'b0000000;
    endcase
    return g;
  endfunction

  // Map an active-high glyph onto the panel's drive polarity.
  function automatic logic [6:0] apply_polarity(input logic [6:0] glyph);
    return ACTIVE_LOW ? ~glyph : glyph;
  endfunction

  logic [6:0] w_seg_p0;
  logic       w_err_p0;
  logic [6:0] r_seg_p1;
  logic       r_err_p1;

  // Stage 0: combinational decode of the incoming code.
  always_comb begin
    w_seg_p0 = apply_polarity(decode_glyph(bus.BCD));
    w_err_p0 = (bus.BCD > 4'd9);
  end

  // Stage 1: output register; reset blanks the digit, en=0 holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg_p1 <= SEG_OFF;
      r_err_p1 <= 1'b0;
    end else if (bus.en) begin
      r_seg_p1 <= w_seg_p0;
      r_err_p1 <= w_err_p0;
    end
  end

`ifndef SYNTHESIS
  // Catch undriven or unknown codes being loaded in simulation.
  always_ff @(posedge clk) begin
    if (!rst && bus.en === 1'b1)
      assert (!$isunknown(bus.BCD))
        else $error("bcd_to_7seg: unknown BCD loaded");
  end
`endif

  assign bus.Seg     = r_seg_p1;
  assign bus.bcd_err = r_err_p1;

endmodule

// File: tb/tb_bcd_to_7seg.sv
// Bench for bcd_to_7seg: three instances (plain, hex glyphs, common-anode)
// driven with identical stimulus and checked against a table-driven model.
`timescale 1ns/1ps
module tb_bcd_to_7seg;

  logic clk;
  logic rst;

  bcd_to_7seg_if if_n ();
  bcd_to_7seg_if if_h ();
  bcd_to_7seg_if if_a ();

  bcd_to_7seg #(.ACTIVE_LOW(1'b0), .HEX_MODE(1'b0)) u_dut_n (.clk(clk), .rst(rst), .bus(if_n));
  bcd_to_7seg #(.ACTIVE_LOW(1'b0), .HEX_MODE(1'b1)) u_dut_h (.clk(clk), .rst(rst), .bus(if_h));
  bcd_to_7seg #(.ACTIVE_LOW(1'b1), .HEX_MODE(1'b0)) u_dut_a (.clk(clk), .rst(rst), .bus(if_a));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference glyphs straight from the display table.
  logic [6:0] dec_glyph [0:9];
  logic [6:0] hex_glyph [0:5];

  // Model state: what each display should show (active-high) and the flag.
  logic [6:0] m_glyph_plain;
  logic [6:0] m_glyph_hex;
  logic       m_err;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] ref_glyph(input int code, input bit hex);
    if (code < 10) return dec_glyph[code];
    if (hex)       return hex_glyph[code - 10];
    return 7'b0000000;
  endfunction

  // Drive one cycle from the falling edge, advance the model at the rising
  // edge, then compare all three instances just after that edge.
  task automatic step(input logic r, input logic e, input logic [3:0] b, input string tag);
    rst = r;
    if_n.en = e; if_h.en = e; if_a.en = e;
    if_n.BCD = b; if_h.BCD = b; if_a.BCD = b;
    @(posedge clk);
    if (r) begin
      m_glyph_plain = 7'b0000000;
      m_glyph_hex   = 7'b0000000;
      m_err         = 1'b0;
    end else if (e) begin
      m_glyph_plain = ref_glyph(int'(b), 1'b0);
      m_glyph_hex   = ref_glyph(int'(b), 1'b1);
      m_err         = (int'(b) >= 10);
    end
    #1;
    check({tag, ".seg_n"}, {1'b0, if_n.Seg},     {1'b0, m_glyph_plain});
    check({tag, ".err_n"}, {7'b0, if_n.bcd_err}, {7'b0, m_err});
    check({tag, ".seg_h"}, {1'b0, if_h.Seg},     {1'b0, m_glyph_hex});
    check({tag, ".err_h"}, {7'b0, if_h.bcd_err}, {7'b0, m_err});
    check({tag, ".seg_a"}, {1'b0, if_a.Seg},     {1'b0, ~m_glyph_plain});
    check({tag, ".err_a"}, {7'b0, if_a.bcd_err}, {7'b0, m_err});
    @(negedge clk);
  endtask

  initial begin
    dec_glyph[0] = 7'b1111110; dec_glyph[1] = 7'b0110000;
    dec_glyph[2] = 7'b1101101; dec_glyph[3] = 7'b1111001;
    dec_glyph[4] = 7'b0110011; dec_glyph[5] = 7'b1011011;
    dec_glyph[6] = 7'b1011111; dec_glyph[7] = 7'b1110000;
    dec_glyph[8] = 7'b1111111; dec_glyph[9] = 7'b1111011;
    hex_glyph[0] = 7'b1110111; hex_glyph[1] = 7'b0011111;
    hex_glyph[2] = 7'b1001110; hex_glyph[3] = 7'b0111101;
    hex_glyph[4] = 7'b1001111; hex_glyph[5] = 7'b1000111;
    m_glyph_plain = 7'b0000000;
    m_glyph_hex   = 7'b0000000;
    m_err         = 1'b0;

    rst = 1'b1;
    if_n.en = 1'b0; if_h.en = 1'b0; if_a.en = 1'b0;
    if_n.BCD = 4'd0; if_h.BCD = 4'd0; if_a.BCD = 4'd0;
    @(negedge clk);

    // Reset wins over en with a valid code present, then 8 loads.
    step(1'b1, 1'b1, 4'd8, "rst8");
    check("rst_const_a", {1'b0, if_a.Seg}, 8'h7F);
    step(1'b0, 1'b1, 4'd8, "load8");
    check("load8_const_n", {1'b0, if_n.Seg}, 8'h7F);

    // Full code sweep, one per cycle.
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 4'(i), "sweep");

    // Hex glyphs A and F.
    step(1'b0, 1'b1, 4'hA, "hexA");
    check("hexA_const", {1'b0, if_h.Seg}, 8'b01110111);
    step(1'b0, 1'b1, 4'hF, "hexF");
    check("hexF_const", {1'b0, if_h.Seg}, 8'b01000111);

    // Common-anode zero.
    step(1'b0, 1'b1, 4'd0, "al0");
    check("al0_const", {1'b0, if_a.Seg}, 8'b00000001);

    // Hold while en is low.
    step(1'b0, 1'b1, 4'd3, "hold_ld");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 4'd7, "hold");
      check("hold_const", {1'b0, if_n.Seg}, 8'b01111001);
    end

    // Reset mid-stream, then the first edge after release loads.
    step(1'b1, 1'b1, 4'd5, "midrst");
    step(1'b0, 1'b1, 4'd5, "post_rst");
    check("post_rst_const", {1'b0, if_n.Seg}, 8'b01011011);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      logic       r, e;
      logic [3:0] b;
      r = ($urandom_range(0, 19) == 0);
      e = ($urandom_range(0, 3) != 0);
      b = 4'($urandom_range(0, 15));
      step(r, e, b, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
